// File: rtl/gf2m_pkg.sv
// gf2m_pkg
//   Shared definitions for the digit-serial GF(2^m) multiplier:
//   - state_t     : controller FSM states
//   - M_DEF/D_DEF : default field degree and digit size
//   - cnt_width() : width of the digit counter, clog2(n) with a floor of 1
package gf2m_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int M_DEF = 16;
  localparam int D_DEF = 4;

  // Bits needed to count 0..n-1; never less than one bit so that a
  // single-cycle run (D == M) still has a legal counter.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/gf2m_ds_mul_ctrl_if.sv
// gf2m_ds_mul_ctrl_if
//   Operand/result bus of the GF(2^m) multiplier.
//   Handshake: a transfer happens on a rising clk edge where valid && ready
//   are both high; the source holds its payload stable while valid && !ready,
//   and ready may depend on internal state only.
//   Input side : in_valid, in_ready, a, b, g
//   Output side: out_valid, out_ready, c
//   master = operand source / result sink, slave = the multiplier.
interface gf2m_ds_mul_ctrl_if #(
  parameter int M = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic [M-1:0] g;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] c;

  modport master (
    output in_valid, a, b, g, out_ready,
    input  in_ready, out_valid, c
  );

  modport slave (
    input  in_valid, a, b, g, out_ready,
    output in_ready, out_valid, c
  );
endinterface

// File: rtl/gf2m_digit_stage.sv
// gf2m_digit_stage
//   Combinational D-step update of the MSB-first interleaved multiplier.
//   Each row applies one iterative step for one multiplier bit:
//     t'_j = (t_(m-1) & g_j) ^ (bi & a_j) ^ t_(j-1),  t_(-1) = 0
//   Rows are chained D deep; row 0 consumes b_bits[D-1] (the MSB of the digit).
//   Ports: t_in  - accumulator before the digit
//          a, g  - multiplicand and field polynomial (g_m = 1 implicit)
//          b_bits- D multiplier bits, MSB first
//          t_out - accumulator after the digit
module gf2m_digit_stage #(
  parameter int M = 16,
  parameter int D = 4
) (
  input  logic [M-1:0] t_in,
  input  logic [M-1:0] a,
  input  logic [M-1:0] g,
  input  logic [D-1:0] b_bits,
  output logic [M-1:0] t_out
);

  always_comb begin
    logic [M-1:0] t_row;
    logic [M-1:0] t_nxt;
    logic         msb;
    logic         bi;
    t_row = t_in;
    t_nxt = '0;
    for (int k = 0; k < D; k++) begin
      msb = t_row[M-1];
      bi  = b_bits[D-1-k];
      t_nxt[0] = (msb & g[0]) ^ (bi & a[0]);
      for (int j = 1; j < M; j++) begin
        t_nxt[j] = (msb & g[j]) ^ (bi & a[j]) ^ t_row[j-1];
      end
      t_row = t_nxt;
    end
    t_out = t_row;
  end

endmodule

// File: rtl/gf2m_ds_mul_ctrl.sv
// gf2m_ds_mul_ctrl
//   Digit-serial GF(2^m) multiplier controller: c = a*b mod G(x).
//   Accepts an operand set in IDLE, spends M/D cycles in RUN consuming D bits
//   of b per cycle (MSB first), then presents c in DONE until taken.
//   Ports: clk, rst_n (async active-low)
//          bus    - operand/result bus (slave side)
//          busy   - high in RUN and DONE
//          state_o- current FSM state, for observation
module gf2m_ds_mul_ctrl
  import gf2m_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int D = D_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gf2m_ds_mul_ctrl_if.slave    bus,
  output logic                 busy,
  output state_t               state_o
);

  if (M < 2) begin : g_bad_m
    $error("gf2m_ds_mul_ctrl: M must be at least 2");
  end
  if (D < 1) begin : g_bad_d
    $error("gf2m_ds_mul_ctrl: D must be at least 1");
  end else if ((M % D) != 0) begin : g_bad_md
    $error("gf2m_ds_mul_ctrl: M must be a multiple of D");
  end

  localparam int NDIG  = (D >= 1) ? (M / D) : 1;
  localparam int CNT_W = cnt_width(NDIG);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

  state_t           state_q, state_d;
  logic [M-1:0]     t_q, t_d;
  logic [M-1:0]     a_q, a_d;
  logic [M-1:0]     g_q, g_d;
  logic [M-1:0]     b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [M-1:0]     t_next;

  gf2m_digit_stage #(.M(M), .D(D)) u_stage (
    .t_in   (t_q),
    .a      (a_q),
    .g      (g_q),
    .b_bits (b_q[M-1 -: D]),
    .t_out  (t_next)
  );

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d     = a_q;
    g_d     = g_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          g_d     = bus.g;
          b_d     = bus.b;
          t_d     = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        t_d   = t_next;
        b_d   = b_q << D;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      a_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      a_q     <= a_d;
      g_q     <= g_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs decode registered state only; c is forced to zero outside
  // DONE so a stale accumulator is never visible.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.c         = (state_q == S_DONE) ? t_q : '0;
  assign busy          = (state_q != S_IDLE);
  assign state_o       = state_q;

endmodule

// File: tb/tb_gf2m_ds_mul_ctrl.sv
module tb_gf2m_ds_mul_ctrl;
  import gf2m_pkg::*;

  localparam int M = 16;
  localparam int D = 4;
  localparam logic [M-1:0] G_DEF = 16'h002B;

  logic   clk;
  logic   rst_n;
  logic   busy;
  state_t state_o;

  gf2m_ds_mul_ctrl_if #(.M(M)) bus ();

  gf2m_ds_mul_ctrl #(.M(M), .D(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy    (busy),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [M-1:0] exp_q[$];
  int checks;
  int passes;
  bit rand_on;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // Reference: carry-less product followed by long-division reduction.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, b, g);
    logic [2*M-1:0] p;
    logic [2*M-1:0] gm;
    p = '0;
    for (int i = 0; i < M; i++)
      if (b[i]) p = p ^ ({{M{1'b0}}, a} << i);
    gm = {{(M-1){1'b0}}, 1'b1, g};
    for (int i = 2*M-2; i >= M; i--)
      if (p[i]) p = p ^ (gm << (i - M));
    return p[M-1:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected_out", 32'(bus.c), 32'hDEAD);
        else check("c", 32'(bus.c), 32'(exp_q.pop_front()));
      end else if (!bus.out_valid) begin
        check("c_zero_idle", 32'(bus.c), 32'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; leaves in_valid high on return.
  task automatic send(input logic [M-1:0] a, b, g);
    bit rdy;
    bit acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.g = g;
    for (int n = 0; n < 200 && !acc; n++) begin
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) acc = 1'b1;
    end
    if (acc) exp_q.push_back(gf_mul(a, b, g));
    else check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Single operation with out_ready high; checks latency.
  task automatic directed(input string tag, input logic [M-1:0] a, b);
    int n;
    bus.out_ready = 1'b1;
    send(a, b, G_DEF);
    bus.in_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_valid(n);
    check({tag, "_lat"}, 32'(n), 32'(M / D));
    @(posedge clk);
    #1;
    check({tag, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [M-1:0] held_c;
    checks = 0;
    passes = 0;
    rand_on = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.g = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_c", 32'(bus.c), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state_o), 32'(S_IDLE));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("one_one", 16'h0001, 16'h0001);
    directed("x15_x", 16'h8000, 16'h0002);
    directed("x_x15", 16'h0002, 16'h8000);
    directed("b_zero", 16'h1234, 16'h0000);
    directed("a_zero", 16'h0000, 16'hBEEF);
    directed("ffff_one", 16'hFFFF, 16'h0001);

    // Backpressure in DONE with a competing operand set on the input.
    bus.out_ready = 1'b0;
    send(16'h1357, 16'h2468, G_DEF);
    bus.in_valid = 1'b0;
    wait_valid(n);
    check("bp_lat", 32'(n), 32'(M / D));
    held_c = gf_mul(16'h1357, 16'h2468, G_DEF);
    bus.in_valid = 1'b1;
    bus.a = 16'hAAAA;
    bus.b = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_c_hold", 32'(bus.c), 32'(held_c));
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_idle_out_valid", 32'(bus.out_valid), 32'd0);
    check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the second RUN cycle aborts the operation.
    send(16'h0F0F, 16'hF0F0, G_DEF);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_c", 32'(bus.c), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    directed("post_rst", 16'h8000, 16'h0002);

    // Random back-to-back traffic with random result backpressure.
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++)
          send(M'($urandom), M'($urandom), M'($urandom));
        bus.in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/gf2m_ds_mul_ctrl.md
GF2M_DS_MUL_CTRL -- requirements
Module: gf2m_ds_mul_ctrl

Interface
REQ-001 Parameter M, default 16, field degree m of GF(2^m); the block SHALL reject (elaboration error) M < 2.
REQ-002 Parameter D, default 4, digit size in bits of b consumed per cycle; the block SHALL reject D < 1 or M % D != 0.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port in_valid  input  1  operand set a, b, g is presented.
REQ-006 Port in_ready  output  1  block accepts operands this cycle.
REQ-007 Port a  input  M  multiplicand, polynomial basis, bit j = coefficient of x^j.
REQ-008 Port b  input  M  multiplier, consumed MSB-first.
REQ-009 Port g  input  M  field polynomial coefficients g0..g(m-1); gm = 1 is implicit.
REQ-010 Port out_valid  output  1  product c is valid.
REQ-011 Port out_ready  input  1  consumer accepts c.
REQ-012 Port c  output  M  product a*b mod G(x).
REQ-013 Port busy  output  1  high in RUN and DONE.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE.
REQ-015 in_ready SHALL equal (state == IDLE), combinationally from state only.
REQ-016 IDLE: on in_valid && in_ready the block SHALL register a, g, b (b into a shift register), clear accumulator t to 0, clear digit counter, and go to RUN.
REQ-017 RUN: each cycle the block SHALL apply D iterative steps to t using the top D bits of the b shift register, MSB first, then shift b left by D.
REQ-018 One iterative step for bit bi: t'_j = (t_(m-1) & g_j) ^ (bi & a_j) ^ t_(j-1), with t_(-1) = 0, for j = 0..M-1.
REQ-019 Digit counter width SHALL be clog2(M/D) (minimum 1); RUN SHALL last exactly M/D cycles, then go to DONE.
REQ-020 Latency: out_valid SHALL rise M/D cycles after the acceptance edge (4 cycles at defaults).
REQ-021 DONE: out_valid = 1 and c = t; c SHALL remain stable while out_valid && !out_ready.
REQ-022 On out_valid && out_ready the block SHALL return to IDLE; in_ready rises the following cycle (no same-cycle input/output overlap).
REQ-023 in_valid while not in_ready SHALL be ignored; operands SHALL NOT be sampled outside the IDLE handshake.
REQ-024 c SHALL be 0 whenever out_valid = 0.
REQ-025 a = 0 or b = 0 SHALL yield c = 0 after the normal latency (no early exit).

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE, t, a, g, b-shift and counter to 0; out_valid = 0, c = 0, busy = 0, in_ready = 1 after reset.
REQ-027 Reset during RUN or DONE SHALL abort the operation with no output; the first post-reset acceptance SHALL behave identically to a cold start.

Structure
REQ-028 A shared package gf2m_pkg SHALL hold the FSM state enum, default M and D, and the clog2-based counter-width function.
REQ-029 The combinational D-step digit update SHALL be one sub-module, gf2m_digit_stage (inputs t, a, g, D b-bits; output next t), built as a chain of D rows of M iterative cells; FSM, counter and registers stay in gf2m_ds_mul_ctrl.

Verification (M=16, D=4, g = 16'h002B, i.e. x^16+x^5+x^3+x+1)
REQ-030 a=16'h0001, b=16'h0001 accepted at edge k -> out_valid high after edge k+4, c=16'h0001.
REQ-031 a=16'h8000, b=16'h0002 -> c=16'h002B; a=16'h0002, b=16'h8000 -> c=16'h002B (commutativity/reduction).
REQ-032 a=16'h1234, b=16'h0000 -> c=16'h0000 after exactly 4 RUN cycles; a=16'hFFFF, b=16'h0001 -> c=16'hFFFF.
REQ-033 Hold out_ready=0 for 3 cycles in DONE with in_valid=1 -> c, out_valid stable, in_ready=0, no new operands taken; out_ready=1 -> IDLE next cycle.
REQ-034 Assert rst_n=0 in the 2nd RUN cycle -> out_valid=0, c=0, in_ready=1 immediately; the next operation a=16'h8000, b=16'h0002 returns c=16'h002B.
REQ-035 1000 random a, b, g with back-to-back in_valid and random out_ready -> every c matches a bit-serial software reference model.
